hart_sequencer: RTL and testbench
=================================

Name: hart_sequencer

Overview:
- Multi-cycle control FSM for a single hart.
- Fetches the instruction word and presents it to the decoder and compute datapath.
- Sequences the data-memory access for loads and stores, then commits the register write and the PC update.
- Owns the architectural PC and a single shared memory port, used for both fetch and data.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  XLEN  request address.
- mem_wdata  out  XLEN  store data.
- mem_rdata  in  XLEN  read data; valid when mem_ready=1.
- mem_ready  in  1  request completes on any edge where mem_req=1 and mem_ready=1.
- instr_word  out  32  latched instruction word, fed to the decoder.
- pc  out  XLEN  current architectural PC.
- dec_is_load  in  1  decoded opcode is LOAD.
- dec_is_store  in  1  decoded opcode is STORE.
- dec_illegal  in  1  decoded opcode is UNKNOWN.
- dec_rd  in  5  destination register index.
- eff_addr  in  XLEN  load/store effective address (rs1 + immediate).
- store_val  in  XLEN  store data from compute.
- rd_out_val  in  XLEN  writeback value from compute.
- rd_out_enable  in  1  compute requests a register write.
- jump_enable  in  1  compute requests a jump/taken branch.
- jump_target_addr  in  XLEN  jump target.
- load_val  out  XLEN  latched load data, fed back to compute.
- reg_we  out  1  register-file write strobe.
- reg_waddr  out  5  register-file write index.
- reg_wdata  out  XLEN  register-file write data.
- retire  out  1  one-cycle pulse per committed instruction.
- halted  out  1  FSM is in HALT.

Behaviour:
- States: FETCH, EXECUTE, MEM, WRITEBACK, HALT.
- Reset:
  - state=FETCH, pc=RESET_PC, instr_word=32'h0000_0013 (NOP), load_val=0.
  - While reset=1: mem_req=0, reg_we=0, retire=0, halted=0.
  - Reset mid-transaction drops mem_req immediately; no register write, no PC change.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - Holds until mem_ready; on that edge instr_word<=mem_rdata, then -> EXECUTE.
- EXECUTE:
  - One cycle; compute settles on instr_word.
  - dec_illegal=1 -> HALT.
  - Else dec_is_load|dec_is_store -> MEM.
  - Else -> WRITEBACK.
- MEM:
  - mem_req=1, mem_addr=eff_addr, mem_we=dec_is_store, mem_wdata=store_val.
  - Holds until mem_ready. On that edge: load_val<=mem_rdata if load (unchanged if store), then -> WRITEBACK.
- WRITEBACK:
  - reg_we = rd_out_enable & (dec_rd != 0); reg_waddr=dec_rd; reg_wdata=rd_out_val.
  - Misaligned jump (jump_enable=1 and jump_target_addr[1:0] != 0) -> HALT: no register write, no retire, pc unchanged.
  - Otherwise pc<=jump_enable ? jump_target_addr : pc+4 (modulo 2^XLEN wrap), retire=1, -> FETCH.
- HALT:
  - Terminal until reset. mem_req=0, reg_we=0, halted=1.
- Handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 and mem_ready=0.
  - mem_ready with mem_req=0 is ignored.
  - mem_req drops for the whole EXECUTE and WRITEBACK cycles.
- Latency with zero wait states:
  - 3 cycles for ALU/jump/branch instructions.
  - 4 cycles for load/store.
  - Each cycle with mem_ready=0 adds 1 cycle.
- Gating:
  - rd=x0 never writes.
  - Stores and not-taken branches never write (rd_out_enable=0 from compute).
- pc, instr_word and load_val change only on the edges defined above.

Optional Feature:
- Macro HART_INSTRET_COUNTER_EN.
- Defined: adds output instret [63:0].
  - Reset to 0; increments by 1 on every edge where retire=1; wraps from 2^64-1 to 0.
  - Holds its value in HALT.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: RESET_PC=32'h100, release reset, mem_ready=1 -> first mem_addr=32'h100 with mem_we=0; ADDI x1 (rd_out_val=15) -> reg_we=1 on cycle 3; pc=32'h104; one retire pulse.
- Fetch wait: hold mem_ready=0 for 3 cycles during FETCH -> mem_req and mem_addr stay constant; instruction retires on cycle 6.
- Load: eff_addr=32'h200, mem_rdata=32'hFA8 -> load_val=32'hFA8; reg_wdata equals compute's sign-extended value 32'hFFFF_FFA8; 4-cycle latency.
- Store: store_val=15, eff_addr=32'h300 -> one mem_req with mem_we=1, mem_wdata=15; reg_we=0; pc+4.
- Jump: pc=32'h100, jump_enable=1 with target 32'h1A8 -> pc=32'h1A8. Target 32'h1AA -> halted=1, no retire, mem_req stays 0 afterward.
- Corner cases: rd=0 with rd_out_enable=1 -> reg_we=0. dec_illegal=1 -> HALT. Reset asserted mid-MEM -> mem_req drops same cycle, pc=RESET_PC.

Source files
------------

// File: rtl/hart_sequencer.sv
// Multi-cycle FETCH/EXECUTE/MEM/WRITEBACK/HALT sequencer for one hart, with a shared fetch/data memory port.
// Optional: define HART_INSTRET_COUNTER_EN to add a 64-bit retired-instruction counter output (instret).
module hart_sequencer #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [31:0]     instr_word,
    output logic [XLEN-1:0] pc,
    input  logic            dec_is_load,
    input  logic            dec_is_store,
    input  logic            dec_illegal,
    input  logic [4:0]      dec_rd,
    input  logic [XLEN-1:0] eff_addr,
    input  logic [XLEN-1:0] store_val,
    input  logic [XLEN-1:0] rd_out_val,
    input  logic            rd_out_enable,
    input  logic            jump_enable,
    input  logic [XLEN-1:0] jump_target_addr,
    output logic [XLEN-1:0] load_val,
    output logic            reg_we,
    output logic [4:0]      reg_waddr,
    output logic [XLEN-1:0] reg_wdata,
    output logic            retire,
    output logic            halted
`ifdef HART_INSTRET_COUNTER_EN
    ,
    output logic [63:0]     instret
`endif
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t state;

    logic in_fetch;
    logic in_mem;
    logic in_wb;
    logic misaligned;
    logic commit;

    assign in_fetch   = (state == S_FETCH);
    assign in_mem     = (state == S_MEM);
    assign in_wb      = (state == S_WRITEBACK) && !reset;
    assign misaligned = jump_enable && (jump_target_addr[1:0] != 2'b00);
    assign commit     = in_wb && !misaligned;

    // Strobes decode straight from the state register so writeback sees the
    // load data latched on the MEM edge; reset masks them asynchronously.
    always_comb begin
        mem_req   = !reset && (in_fetch || in_mem);
        mem_we    = in_mem && dec_is_store;
        mem_addr  = in_mem ? eff_addr : pc;
        mem_wdata = in_mem ? store_val : '0;
        reg_we    = commit && rd_out_enable && (dec_rd != 5'd0);
        reg_waddr = dec_rd;
        reg_wdata = rd_out_val;
        retire    = commit;
        halted    = !reset && (state == S_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            instr_word <= 32'h0000_0013;
            load_val   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        instr_word <= mem_rdata[31:0];
                        state      <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (dec_illegal) begin
                        state <= S_HALT;
                    end else if (dec_is_load || dec_is_store) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WRITEBACK;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (dec_is_load && !dec_is_store) begin
                            load_val <= mem_rdata;
                        end
                        state <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    if (misaligned) begin
                        state <= S_HALT;
                    end else begin
                        pc    <= jump_enable ? jump_target_addr : pc + XLEN'(4);
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

`ifdef HART_INSTRET_COUNTER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hart_sequencer.sv
// Directed scoreboard bench for hart_sequencer: mock memory/compute, expected writebacks queued per instruction.
`timescale 1ns/1ps
module tb_hart_sequencer;
    localparam int unsigned XLEN   = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b1;
    logic [31:0] instr_word, pc;
    logic        dec_is_load = 0, dec_is_store = 0, dec_illegal = 0;
    logic [4:0]  dec_rd = '0;
    logic [31:0] eff_addr = '0, store_val = '0, rd_out_val = '0;
    logic        rd_out_enable = 0, jump_enable = 0;
    logic [31:0] jump_target_addr = '0;
    logic [31:0] load_val;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        retire, halted;
`ifdef HART_INSTRET_COUNTER_EN
    logic [63:0] instret;
`endif

    always #5 clk = ~clk;

    hart_sequencer #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .instr_word(instr_word), .pc(pc),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_illegal(dec_illegal),
        .dec_rd(dec_rd), .eff_addr(eff_addr), .store_val(store_val),
        .rd_out_val(rd_out_val), .rd_out_enable(rd_out_enable),
        .jump_enable(jump_enable), .jump_target_addr(jump_target_addr),
        .load_val(load_val), .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .retire(retire), .halted(halted)
`ifdef HART_INSTRET_COUNTER_EN
        , .instret(instret)
`endif
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wr_t;

    typedef struct {
        logic [31:0] word;
        logic        ld, st, ill;
        logic [4:0]  rd;
        logic [31:0] eff, sval, rval;
        logic        rden, jen;
        logic [31:0] jtgt, ldata;
        int          fwait, mwait;
    } ins_t;

    wr_t         sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_instret = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Writeback monitor: every retire pops one expected register-file transaction.
    always @(negedge clk) begin
        if (!reset && retire) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_retire", 64'(sb.size() > 0), 64'd1);
            end else begin
                wr_t w;
                w = sb.pop_front();
                check("wb_reg_we", reg_we, w.we);
                if (w.we) begin
                    check("wb_reg_waddr", reg_waddr, w.waddr);
                    check("wb_reg_wdata", reg_wdata, w.wdata);
                end
            end
        end
        if (!reset && reg_we) check("we_without_retire", retire, 1'b1);
    end

    task automatic apply(input ins_t i);
        dec_is_load = i.ld;  dec_is_store = i.st;  dec_illegal = i.ill;
        dec_rd = i.rd;  eff_addr = i.eff;  store_val = i.sval;
        rd_out_val = i.rval;  rd_out_enable = i.rden;
        jump_enable = i.jen;  jump_target_addr = i.jtgt;
        mem_rdata = i.word;  mem_ready = 1'b0;
    endtask

    function automatic ins_t mk(input logic [31:0] word, input logic [4:0] rd, input logic rden,
                                input logic [31:0] rval);
        ins_t i;
        i.word = word; i.ld = 0; i.st = 0; i.ill = 0; i.rd = rd; i.eff = '0; i.sval = '0;
        i.rval = rval; i.rden = rden; i.jen = 0; i.jtgt = '0; i.ldata = '0;
        i.fwait = 0; i.mwait = 0;
        return i;
    endfunction

    // Plays memory for one instruction; called right after a rising edge with the DUT in FETCH.
    task automatic run_instr(input string tag, input ins_t i, input logic [31:0] pc0,
                             input int exp_lat, input logic exp_ret, input logic [31:0] exp_pc);
        int   lat = 0, waited = 0, nst = 0;
        logic ph = 0, fin = 0, saw_ret = 0;
        wr_t  w;
        apply(i);
        if (exp_ret) begin
            w.we = i.rden && (i.rd != 5'd0); w.waddr = i.rd; w.wdata = i.rval;
            sb.push_back(w);
        end
        while (!fin && lat < 40) begin
            @(negedge clk);
            lat++;
            mem_ready = 1'b1;
            if (mem_req) begin
                if (!ph) begin
                    check({tag, "_fetch_addr"}, mem_addr, pc0);
                    check({tag, "_fetch_we"}, mem_we, 1'b0);
                    mem_rdata = i.word;
                    mem_ready = (waited == i.fwait);
                    if (mem_ready) begin ph = 1; waited = 0; end else waited++;
                end else begin
                    check({tag, "_data_addr"}, mem_addr, i.eff);
                    check({tag, "_data_we"}, mem_we, i.st);
                    if (i.st) check({tag, "_data_wdata"}, mem_wdata, i.sval);
                    mem_rdata = i.ldata;
                    mem_ready = (waited == i.mwait);
                    if (mem_ready) begin
                        if (mem_we) nst++;
                        waited = 0;
                    end else waited++;
                end
            end
            if (retire) begin saw_ret = 1; fin = 1; end
            if (halted) fin = 1;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_retired"}, saw_ret, exp_ret);
        check({tag, "_halted"}, halted, !exp_ret);
        if (i.st) check({tag, "_store_count"}, nst, 1);
        @(posedge clk);
        #1;
        if (exp_ret) exp_instret = exp_instret + 64'd1;
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_instr_word"}, instr_word, i.word);
`ifdef HART_INSTRET_COUNTER_EN
        check({tag, "_instret"}, instret, exp_instret);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_pc", pc, RST_PC);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_instret = '0;
    endtask

    initial begin
        ins_t i;

        // Reset state
        @(negedge clk);
        check("reset_mem_req", mem_req, 1'b0);
        check("reset_reg_we", reg_we, 1'b0);
        check("reset_retire", retire, 1'b0);
        check("reset_halted", halted, 1'b0);
        check("reset_pc", pc, RST_PC);
        check("reset_instr", instr_word, 32'h0000_0013);
        check("reset_load_val", load_val, 32'h0);
`ifdef HART_INSTRET_COUNTER_EN
        check("reset_instret", instret, 64'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ADDI x1, x0, 15
        i = mk(32'h00F0_0093, 5'd1, 1'b1, 32'd15);
        run_instr("addi", i, 32'h100, 3, 1'b1, 32'h104);

        // Fetch held off for three cycles
        i = mk(32'h0070_0113, 5'd2, 1'b1, 32'd7);
        i.fwait = 3;
        run_instr("fwait", i, 32'h104, 6, 1'b1, 32'h108);

        // LB x3: memory returns 0xFA8, compute sign-extends
        i = mk(32'h0000_0183, 5'd3, 1'b1, 32'hFFFF_FFA8);
        i.ld = 1; i.eff = 32'h200; i.ldata = 32'hFA8;
        run_instr("load", i, 32'h108, 4, 1'b1, 32'h10C);
        check("load_val_fa8", load_val, 32'hFA8);

        // Load with two data wait states
        i = mk(32'h0000_2203, 5'd4, 1'b1, 32'h1234_5678);
        i.ld = 1; i.eff = 32'h204; i.ldata = 32'h1234_5678; i.mwait = 2;
        run_instr("load_wait", i, 32'h10C, 6, 1'b1, 32'h110);
        check("load_val_wait", load_val, 32'h1234_5678);

        // SW: one write request, no register write, load_val untouched
        i = mk(32'h00F0_2023, 5'd0, 1'b0, 32'hDEAD_BEEF);
        i.st = 1; i.eff = 32'h300; i.sval = 32'd15; i.ldata = 32'hBAD0_BAD0;
        run_instr("store", i, 32'h110, 4, 1'b1, 32'h114);
        check("store_load_val_kept", load_val, 32'h1234_5678);

        // rd = x0 with write enable must not write
        i = mk(32'h0050_0013, 5'd0, 1'b1, 32'd5);
        run_instr("rd_x0", i, 32'h114, 3, 1'b1, 32'h118);

        // Reset in the middle of a MEM wait
        i = mk(32'h0000_2283, 5'd5, 1'b1, 32'h55);
        i.ld = 1; i.eff = 32'h400; i.ldata = 32'h55;
        apply(i);
        @(negedge clk);
        check("midmem_fetch_req", mem_req, 1'b1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        check("midmem_req", mem_req, 1'b1);
        check("midmem_addr", mem_addr, 32'h400);
        #1;
        reset = 1'b1;
        #1;
        check("midmem_req_drop", mem_req, 1'b0);
        check("midmem_pc", pc, RST_PC);
        check("midmem_reg_we", reg_we, 1'b0);
        check("midmem_load_val", load_val, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_instret = '0;

        // JAL x1 to aligned target
        i = mk(32'h0A80_00EF, 5'd1, 1'b1, 32'h104);
        i.jen = 1; i.jtgt = 32'h1A8;
        run_instr("jump", i, 32'h100, 3, 1'b1, 32'h1A8);

        // Misaligned target: halt, no write, pc kept
        i = mk(32'h0020_00EF, 5'd1, 1'b1, 32'h1AC);
        i.jen = 1; i.jtgt = 32'h1AA;
        run_instr("misalign", i, 32'h1A8, 4, 1'b0, 32'h1A8);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            check("halt_mem_req", mem_req, 1'b0);
            check("halt_flag", halted, 1'b1);
            check("halt_pc", pc, 32'h1A8);
`ifdef HART_INSTRET_COUNTER_EN
            check("halt_instret", instret, exp_instret);
`endif
        end

        // Illegal opcode after one good instruction
        do_reset();
        i = mk(32'h0010_0093, 5'd1, 1'b1, 32'd1);
        run_instr("pre_ill", i, 32'h100, 3, 1'b1, 32'h104);
        i = mk(32'hFFFF_FFFF, 5'd7, 1'b1, 32'd9);
        i.ill = 1;
        run_instr("illegal", i, 32'h104, 3, 1'b0, 32'h104);
        @(negedge clk);
        check("illegal_mem_req", mem_req, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
